dmem_port_arbiter: RTL and testbench

- Sequencer and arbiter for port A of the 16-bit-word, byte-addressed data RAM.
- Shares port A between two requesters: the CPU load/store unit (requester 0) and the image DMA/filter engine (requester 1).
- Converts byte-address requests of 1 or 2 bytes into word accesses with byte enables.
- Splits misaligned 2-byte accesses (odd address) into two word accesses and re-assembles the read data.
- Port B (VGA read) is untouched.

---
 rtl/dmem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Port-A sequencer for the 16-bit data RAM: arbitrates CPU and DMA requests and
// turns 1/2-byte byte-addressed accesses into word accesses, splitting odd 2-byte ones.
module dmem_port_arbiter #(
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic              two_byte0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [15:0]       wdata0,
  output logic              ack0,
  output logic [15:0]       rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              two_byte1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [15:0]       wdata1,
  output logic              ack1,
  output logic [15:0]       rdata1,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [1:0]        mem_byteena,
  output logic [15:0]       mem_wdata,
  output logic              mem_wren,
  input  logic [15:0]       mem_q,
  output logic              busy,
  output logic              owner
);

  localparam int WA_W = ADDR_W - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P0W  = 3'd2,
    P1   = 3'd3,
    P1W  = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic              we_r, we_s;
  logic              two_byte_r, two_byte_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [15:0]       wdata_r, wdata_s;
  logic              last_grant_r, last_grant_s;
  logic [7:0]        lo_byte_r, lo_byte_s;

  logic [WA_W-1:0]   mem_addr_r, mem_addr_s;
  logic [1:0]        mem_byteena_r, mem_byteena_s;
  logic [15:0]       mem_wdata_r, mem_wdata_s;
  logic              mem_wren_r, mem_wren_s;
  logic              ack0_r, ack0_s, ack1_r, ack1_s;
  logic [15:0]       rdata0_r, rdata0_s, rdata1_r, rdata1_s;
  logic              busy_r, busy_s;
  logic              owner_r, owner_s;

  logic              sel_s;
  logic              sel_we_s;
  logic              sel_two_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [15:0]       sel_wdata_s;
  logic [15:0]       first_word_s;
  logic [15:0]       resp_word_s;

  function automatic logic [1:0] first_byteena(input logic two_byte, input logic odd);
    logic [1:0] be;
    if (two_byte && !odd) begin
      be = 2'b11;
    end else if (odd) begin
      be = 2'b10;
    end else begin
      be = 2'b01;
    end
    return be;
  endfunction

  function automatic logic [15:0] first_wdata(input logic [15:0] wd, input logic odd);
    return odd ? {wd[7:0], 8'h00} : wd;
  endfunction

  // Read data from the first word, already shifted so the addressed byte sits in [7:0].
  function automatic logic [15:0] first_rdata(input logic [15:0] q, input logic two_byte,
                                              input logic odd);
    logic [15:0] d;
    if (two_byte && !odd) begin
      d = q;
    end else if (odd) begin
      d = {8'h00, q[15:8]};
    end else begin
      d = {8'h00, q[7:0]};
    end
    return d;
  endfunction

  // Next-state, request capture and registered-output values.
  always_comb begin
    state_s       = state_r;
    we_s          = we_r;
    two_byte_s    = two_byte_r;
    addr_s        = addr_r;
    wdata_s       = wdata_r;
    last_grant_s  = last_grant_r;
    lo_byte_s     = lo_byte_r;
    mem_addr_s    = mem_addr_r;
    mem_byteena_s = mem_byteena_r;
    mem_wdata_s   = mem_wdata_r;
    mem_wren_s    = 1'b0;
    ack0_s        = 1'b0;
    ack1_s        = 1'b0;
    rdata0_s      = rdata0_r;
    rdata1_s      = rdata1_r;
    owner_s       = owner_r;

    // Round-robin on a tie: the requester that did not win last time.
    if (req0 && req1) begin
      sel_s = ~last_grant_r;
    end else begin
      sel_s = req1;
    end
    sel_we_s     = sel_s ? we1       : we0;
    sel_two_s    = sel_s ? two_byte1 : two_byte0;
    sel_addr_s   = sel_s ? addr1     : addr0;
    sel_wdata_s  = sel_s ? wdata1    : wdata0;
    first_word_s = first_rdata(mem_q, two_byte_r, addr_r[0]);
    resp_word_s  = 16'h0000;

    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          we_s          = sel_we_s;
          two_byte_s    = sel_two_s;
          addr_s        = sel_addr_s;
          wdata_s       = sel_wdata_s;
          owner_s       = sel_s;
          last_grant_s  = sel_s;
          mem_addr_s    = sel_addr_s[ADDR_W-1:1];
          mem_byteena_s = first_byteena(sel_two_s, sel_addr_s[0]);
          mem_wdata_s   = first_wdata(sel_wdata_s, sel_addr_s[0]);
          mem_wren_s    = sel_we_s;
          state_s       = P0;
        end else begin
          state_s = IDLE;
        end
      end
      P0: begin
        state_s = P0W;
      end
      P0W: begin
        lo_byte_s = first_word_s[7:0];
        if (two_byte_r && addr_r[0]) begin
          mem_addr_s    = addr_r[ADDR_W-1:1] + WA_W'(1);
          mem_byteena_s = 2'b01;
          mem_wdata_s   = {8'h00, wdata_r[15:8]};
          mem_wren_s    = we_r;
          state_s       = P1;
        end else begin
          resp_word_s = we_r ? 16'h0000 : first_word_s;
          if (owner_r) begin
            ack1_s   = 1'b1;
            rdata1_s = resp_word_s;
          end else begin
            ack0_s   = 1'b1;
            rdata0_s = resp_word_s;
          end
          state_s = RESP;
        end
      end
      P1: begin
        state_s = P1W;
      end
      P1W: begin
        resp_word_s = we_r ? 16'h0000 : {mem_q[7:0], lo_byte_r};
        if (owner_r) begin
          ack1_s   = 1'b1;
          rdata1_s = resp_word_s;
        end else begin
          ack0_s   = 1'b1;
          rdata0_s = resp_word_s;
        end
        state_s = RESP;
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Captured request fields, arbitration history and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_r          <= 1'b0;
      two_byte_r    <= 1'b0;
      addr_r        <= '0;
      wdata_r       <= 16'h0000;
      last_grant_r  <= 1'b1;
      lo_byte_r     <= 8'h00;
      mem_addr_r    <= '0;
      mem_byteena_r <= 2'b00;
      mem_wdata_r   <= 16'h0000;
      mem_wren_r    <= 1'b0;
      ack0_r        <= 1'b0;
      ack1_r        <= 1'b0;
      rdata0_r      <= 16'h0000;
      rdata1_r      <= 16'h0000;
      busy_r        <= 1'b0;
      owner_r       <= 1'b0;
    end else begin
      we_r          <= we_s;
      two_byte_r    <= two_byte_s;
      addr_r        <= addr_s;
      wdata_r       <= wdata_s;
      last_grant_r  <= last_grant_s;
      lo_byte_r     <= lo_byte_s;
      mem_addr_r    <= mem_addr_s;
      mem_byteena_r <= mem_byteena_s;
      mem_wdata_r   <= mem_wdata_s;
      mem_wren_r    <= mem_wren_s;
      ack0_r        <= ack0_s;
      ack1_r        <= ack1_s;
      rdata0_r      <= rdata0_s;
      rdata1_r      <= rdata1_s;
      busy_r        <= busy_s;
      owner_r       <= owner_s;
    end
  end

  assign mem_addr    = mem_addr_r;
  assign mem_byteena = mem_byteena_r;
  assign mem_wdata   = mem_wdata_r;
  assign mem_wren    = mem_wren_r;
  assign ack0        = ack0_r;
  assign ack1        = ack1_r;
  assign rdata0      = rdata0_r;
  assign rdata1      = rdata1_r;
  assign busy        = busy_r;
  assign owner       = owner_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a small RAM model, expected writes and
// acks queued by the stimulus, and a negedge monitor that pops and compares them.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, two_byte0, req1, we1, two_byte1;
  logic [18:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [17:0] mem_addr;
  logic [1:0]  mem_byteena;
  logic [15:0] mem_wdata;
  logic        mem_wren;
  logic [15:0] mem_q;
  logic        busy, owner;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [0:1023];
  logic        ram_clr;
  logic [35:0] wr_q [$];
  logic [16:0] ack_q [$];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(19)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .two_byte0(two_byte0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .two_byte1(two_byte1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_byteena(mem_byteena), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy), .owner(owner)
  );

  // RAM model: one-cycle read latency, old data on read-during-write.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 16'h0000;
      mem_q <= 16'h0000;
    end else begin
      mem_q <= ram[mem_addr[9:0]];
      if (mem_wren) begin
        if (mem_byteena[0]) ram[mem_addr[9:0]][7:0]  <= mem_wdata[7:0];
        if (mem_byteena[1]) ram[mem_addr[9:0]][15:8] <= mem_wdata[15:8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [17:0] a, input logic [1:0] be, input logic [15:0] d);
    wr_q.push_back({a, be, d});
  endtask

  task automatic push_ack(input logic r, input logic [15:0] d);
    ack_q.push_back({r, d});
  endtask

  // Monitor: every RAM write and every ack must match the head of its queue.
  always @(negedge clk) begin
    logic [35:0] ew;
    logic [16:0] ea;
    if (mem_wren === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected write: addr %h be %b data %h", mem_addr, mem_byteena, mem_wdata);
      end else begin
        ew = wr_q.pop_front();
        chk("write addr", 32'(mem_addr), 32'(ew[35:18]));
        chk("write byteena", 32'(mem_byteena), 32'(ew[17:16]));
        chk("write data", 32'(mem_wdata), 32'(ew[15:0]));
      end
    end
    if (ack0 === 1'b1 && ack1 === 1'b1) begin
      checks++; errors++;
      $display("FAIL dual ack: ack0 %b ack1 %b required one", ack0, ack1);
    end else if (ack0 === 1'b1 || ack1 === 1'b1) begin
      if (ack_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected ack: ack0 %b ack1 %b", ack0, ack1);
      end else begin
        ea = ack_q.pop_front();
        chk("ack requester", 32'(ack1), 32'(ea[16]));
        chk("rdata", 32'(ea[16] ? rdata1 : rdata0), 32'(ea[15:0]));
      end
    end
  end

  task automatic issue(input logic r, input logic we, input logic tb, input logic [18:0] a,
                       input logic [15:0] wd);
    if (r) begin
      we1 = we; two_byte1 = tb; addr1 = a; wdata1 = wd; req1 = 1'b1;
    end else begin
      we0 = we; two_byte0 = tb; addr0 = a; wdata0 = wd; req0 = 1'b1;
    end
  endtask

  // Counts negedges from the issue point to the ack, then drops req and lets the DUT idle.
  task automatic wait_ack(input logic r, input int exp_lat, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(r ? ack1 : ack0) && n < 40);
    chk({name, " latency"}, 32'(n), 32'(exp_lat));
    if (r) req1 = 1'b0;
    else   req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input logic r, input logic we, input logic tb, input logic [18:0] a,
                     input logic [15:0] wd, input logic [15:0] exp_rd, input int lat,
                     input string name);
    push_ack(r, exp_rd);
    issue(r, we, tb, a, wd);
    wait_ack(r, lat, name);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " ack"}, 32'({ack0, ack1}), 32'd0);
    chk({tag, " rdata0"}, 32'(rdata0), 32'd0);
    chk({tag, " rdata1"}, 32'(rdata1), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " mem_be/wren"}, 32'({mem_byteena, mem_wren}), 32'd0);
    chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, " busy/owner"}, 32'({busy, owner}), 32'd0);
  endtask

  initial begin
    int acks;
    int since;
    int cyc;
    reset = 1'b0; ram_clr = 1'b1;
    req0 = 1'b0; we0 = 1'b0; two_byte0 = 1'b0; addr0 = 19'h0; wdata0 = 16'h0;
    req1 = 1'b0; we1 = 1'b0; two_byte1 = 1'b0; addr1 = 19'h0; wdata1 = 16'h0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    ram_clr = 1'b0; reset = 1'b1;
    @(negedge clk);

    // Aligned, single-byte and split accesses from the CPU.
    push_wr(18'h00008, 2'b11, 16'hBEEF);
    run(1'b0, 1'b1, 1'b1, 19'h00010, 16'hBEEF, 16'h0000, 3, "aligned write");
    run(1'b0, 1'b0, 1'b1, 19'h00010, 16'h0000, 16'hBEEF, 3, "aligned read");
    push_wr(18'h00008, 2'b10, 16'h5500);
    run(1'b0, 1'b1, 1'b0, 19'h00011, 16'h0055, 16'h0000, 3, "byte write odd");
    run(1'b0, 1'b0, 1'b1, 19'h00010, 16'h0000, 16'h55EF, 3, "merged read");
    run(1'b0, 1'b0, 1'b0, 19'h00010, 16'h0000, 16'h00EF, 3, "byte read even");
    run(1'b1, 1'b0, 1'b0, 19'h00011, 16'h0000, 16'h0055, 3, "dma byte read odd");
    chk("rdata0 hold", 32'(rdata0), 32'h000000EF);
    push_wr(18'h00010, 2'b10, 16'h3400);
    push_wr(18'h00011, 2'b01, 16'h0012);
    run(1'b0, 1'b1, 1'b1, 19'h00021, 16'h1234, 16'h0000, 5, "split write");
    run(1'b0, 1'b0, 1'b1, 19'h00021, 16'h0000, 16'h1234, 5, "split read");

    // Word-address wrap on the second half of a split.
    push_wr(18'h3FFFF, 2'b10, 16'h5A00);
    push_wr(18'h00000, 2'b01, 16'h00A5);
    run(1'b1, 1'b1, 1'b1, 19'h7FFFF, 16'hA55A, 16'h0000, 5, "wrap write");
    run(1'b1, 1'b0, 1'b1, 19'h7FFFF, 16'h0000, 16'hA55A, 5, "wrap read");

    // Both requesting from reset: CPU, DMA, CPU, DMA with one idle cycle between.
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push_ack(1'b0, 16'h55EF); push_ack(1'b1, 16'h1234);
    push_ack(1'b0, 16'h55EF); push_ack(1'b1, 16'h1234);
    issue(1'b0, 1'b0, 1'b1, 19'h00010, 16'h0000);
    issue(1'b1, 1'b0, 1'b1, 19'h00021, 16'h0000);
    reset = 1'b1;
    acks = 0; since = 10; cyc = 0;
    while (acks < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      since++;
      if (since == 1) begin
        chk("arb idle gap busy", 32'(busy), 32'd0);
        chk("arb single-cycle ack", 32'({ack0, ack1}), 32'd0);
      end
      if (since == 2) chk("arb busy after gap", 32'(busy), 32'd1);
      if (ack0 || ack1) begin
        acks++;
        since = 0;
      end
    end
    chk("arb ack count", 32'(acks), 32'd4);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset in P0W of a split write: first half lands, no second half, no ack.
    push_wr(18'h00018, 2'b10, 16'hCD00);
    issue(1'b0, 1'b1, 1'b1, 19'h00031, 16'hABCD);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; req0 = 1'b0;
    issue(1'b1, 1'b0, 1'b1, 19'h00030, 16'h0000);
    @(negedge clk);
    chk_zero_outputs("mid-op reset");
    push_ack(1'b1, 16'hCD00);
    reset = 1'b1;
    wait_ack(1'b1, 3, "post-reset dma");

    repeat (4) @(negedge clk);
    chk("write queue drained", 32'(wr_q.size()), 32'd0);
    chk("ack queue drained", 32'(ack_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
